instr_encoder_loader: RTL and testbench

- Inverse of the opcode decoder: takes a one-hot instruction class plus operand fields, encodes a 32-bit instruction word, buffers it, and writes it sequentially into instruction memory.
- Used by the boot/test loader path to fill imem before the single-cycle core is released from reset.
- The block has an input valid/ready handshake, a 4-entry FIFO, a registered imem write port and a session state machine.

---
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes instruction fields, buffers them and writes them into imem
module instr_encoder_loader #(
   parameter int AW        = 12,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 4096
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          finish,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [10:0]   op_sel,
   input  logic [4:0]    rd,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    shamt,
   input  logic [4:0]    aluop,
   input  logic [16:0]   imm,
   input  logic [26:0]   target,
   output logic          imem_wren,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   MAXW  = MAX_WORDS[AW:0];
   localparam logic [AW-1:0] BASE  = BASE_ADDR[AW-1:0];
   localparam logic [AW:0]   ONE_C = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
   state_t state, state_n;

   logic [31:0]   word;
   logic          op_ok;
   logic [31:0]   fifo_mem [4];
   logic [1:0]    rd_ptr, wr_ptr;
   logic [2:0]    fifo_cnt;
   logic [AW-1:0] wptr;
   logic [AW:0]   accepted;
   logic          active, fifo_empty, fifo_full, xfer, push, pop, start_ok;

   // Exactly one class bit selects a format; anything else is flagged invalid.
   always_comb begin
      word  = '0;
      op_ok = 1'b1;
      case (op_sel)
         11'b100_0000_0000: word = {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
         11'b010_0000_0000: word = {5'b00101, rd, rs, imm};
         11'b001_0000_0000: word = {5'b00111, rd, rs, imm};
         11'b000_1000_0000: word = {5'b01000, rd, rs, imm};
         11'b000_0100_0000: word = {5'b00001, target};
         11'b000_0010_0000: word = {5'b00010, rd, rs, imm};
         11'b000_0001_0000: word = {5'b00011, target};
         11'b000_0000_1000: word = {5'b00100, rd, 22'd0};
         11'b000_0000_0100: word = {5'b00110, rd, rs, imm};
         11'b000_0000_0010: word = {5'b10110, target};
         11'b000_0000_0001: word = {5'b10101, target};
         default:           op_ok = 1'b0;
      endcase
   end

   assign active     = (state == LOAD) || (state == FLUSH);
   assign fifo_empty = (fifo_cnt == 3'd0);
   assign fifo_full  = (fifo_cnt == 3'd4);
   assign in_ready   = (state == LOAD) && !fifo_full && (accepted < MAXW);
   assign xfer       = in_valid && in_ready;
   assign push       = xfer && op_ok;
   assign pop        = active && !fifo_empty;
   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign busy       = active;
   assign done       = (state == DONE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = LOAD;
         LOAD:    if (finish) state_n = FLUSH;
         FLUSH:   if (fifo_empty) state_n = DONE;
         DONE:    if (start) state_n = LOAD;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= word;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifo_cnt  <= '0;
         wptr      <= BASE;
         accepted  <= '0;
         count     <= '0;
         err       <= 1'b0;
         imem_wren <= 1'b0;
         imem_addr <= '0;
         imem_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
         if (pop) begin
            rd_ptr    <= rd_ptr + 2'd1;
            imem_wren <= 1'b1;
            imem_addr <= wptr;
            imem_data <= fifo_mem[rd_ptr];
            wptr      <= wptr + ONE_A;
            count     <= count + ONE_C;
         end else begin
            imem_wren <= 1'b0;
         end
         if (start_ok) begin
            wptr     <= BASE;
            count    <= '0;
            accepted <= '0;
            err      <= 1'b0;
         end else begin
            if (push) accepted <= accepted + ONE_C;
            if (xfer && !op_ok) err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;
   localparam int AW   = 12;
   localparam int BASE = 0;
   localparam int MAXW = 6;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic          in_ready;
   logic [10:0]   op_sel = '0;
   logic [4:0]    rd = '0, rs = '0, rt = '0, shamt = '0, aluop = '0;
   logic [16:0]   imm = '0;
   logic [26:0]   target = '0;
   logic          imem_wren, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic [AW:0]   count;

   always #5 clock = ~clock;

   instr_encoder_loader #(.AW(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
      .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
      .imm(imm), .target(target), .imem_wren(imem_wren), .imem_addr(imem_addr),
      .imem_data(imem_data), .busy(busy), .done(done), .err(err), .count(count)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cnt;
   } wr_t;

   wr_t         exp_q[$];
   int          tests = 0, fails = 0;
   int          sess_n = 0, nwrites = 0;
   bit          exp_err = 0, open = 0;
   logic [31:0] last_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference encoder: opcode table indexed by class bit, field placement by format.
   function automatic logic [31:0] model_word(input logic [10:0] s, input logic [4:0] f_rd,
         input logic [4:0] f_rs, input logic [4:0] f_rt, input logic [4:0] f_sh,
         input logic [4:0] f_alu, input logic [16:0] f_imm, input logic [26:0] f_tg,
         output bit ok);
      int     opc [11] = '{21, 22, 6, 4, 3, 2, 1, 8, 7, 5, 0};
      int     ones = 0, idx = 0;
      longint w;
      for (int i = 0; i < 11; i++) if (s[i]) begin ones++; idx = i; end
      ok = (ones == 1);
      if (!ok) return 32'h0;
      w = longint'(opc[idx]) << 27;
      case (idx)
         10:           w += (longint'(f_rd) << 22) + (longint'(f_rs) << 17) + (longint'(f_rt) << 12)
                            + (longint'(f_sh) << 7) + (longint'(f_alu) << 2);
         9, 8, 7, 5, 2: w += (longint'(f_rd) << 22) + (longint'(f_rs) << 17) + longint'(f_imm);
         3:            w += longint'(f_rd) << 22;
         default:      w += longint'(f_tg);
      endcase
      return w[31:0];
   endfunction

   always @(negedge clock) begin
      if (reset_n && imem_wren) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", imem_addr, imem_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(imem_addr), 64'(e.addr));
            chk("wr_data", 64'(imem_data), 64'(e.data));
            chk("wr_count", 64'(count), 64'(e.cnt));
         end
         last_data = imem_data;
         nwrites++;
      end
   end

   task automatic send(input logic [10:0] s, input logic [4:0] a_rd, input logic [4:0] a_rs,
         input logic [4:0] a_rt, input logic [4:0] a_sh, input logic [4:0] a_alu,
         input logic [16:0] a_imm, input logic [26:0] a_tg);
      bit          ok = 0, vop;
      logic [31:0] w;
      op_sel = s; rd = a_rd; rs = a_rs; rt = a_rt; shamt = a_sh; aluop = a_alu;
      imm = a_imm; target = a_tg; in_valid = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clock);
         if (in_ready) begin
            ok = 1;
            w = model_word(s, a_rd, a_rs, a_rt, a_sh, a_alu, a_imm, a_tg, vop);
            if (vop) begin
               sess_n++;
               exp_q.push_back('{AW'(BASE + sess_n - 1), w, sess_n});
            end else begin
               exp_err = 1;
            end
         end
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      chk("handshake", 64'(ok), 64'(1));
   endtask

   task automatic send_rand(input logic [10:0] s);
      send(s, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           17'($urandom), 27'($urandom));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      if (!open) begin
         open = 1; sess_n = 0; exp_err = 0;
      end
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      @(posedge clock); #1;
      finish = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0, bad_rdy = 0, bad_busy = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clock);
         if (done) seen = 1;
         else begin
            if (in_ready) bad_rdy = 1;
            if (!busy) bad_busy = 1;
         end
      end
      chk("done_reached", 64'(seen), 64'(1));
      chk("flush_ready_low", 64'(bad_rdy), 64'(0));
      chk("flush_busy", 64'(bad_busy), 64'(0));
      chk("final_count", 64'(count), 64'(sess_n));
      chk("drained", 64'(exp_q.size()), 64'(0));
      chk("final_err", 64'(err), 64'(exp_err));
      @(posedge clock); #1;
      open = 0;
   endtask

   task automatic try_reject();
      bit bad = 0;
      op_sel = 11'h200; in_valid = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clock);
         if (in_ready) bad = 1;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      chk("capacity_ready_low", 64'(bad), 64'(0));
   endtask

   function automatic logic [10:0] rand_sel();
      logic [10:0] s = '0;
      int b1, b2;
      if ($urandom_range(0, 7) == 0) begin
         if ($urandom_range(0, 1) == 0) return s;
         b1 = $urandom_range(0, 10);
         b2 = (b1 + 1 + $urandom_range(0, 9)) % 11;
         s[b1] = 1'b1; s[b2] = 1'b1;
      end else begin
         s[$urandom_range(0, 10)] = 1'b1;
      end
      return s;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int saved;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_wren", 64'(imem_wren), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(0));
      chk("rst_busy_done", 64'({busy, done, err}), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      reset_n = 1'b1;
      @(posedge clock); #1;

      // addi with two-edge latency, then a back-to-back burst
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'(1));
      send(11'h200, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0);
      chk("lat_one_edge", 64'(imem_wren), 64'(0));
      @(posedge clock); #1;
      chk("lat_two_edges", 64'(imem_wren), 64'(1));
      chk("addi_word", 64'(imem_data), 64'(32'h28400005));
      chk("addi_count", 64'(count), 64'(1));
      send(11'h400, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0);
      send(11'h040, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100);
      send(11'h008, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
      send(11'h001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd7);
      repeat (3) @(posedge clock);
      #1;
      chk("setx_word", 64'(last_data), 64'(32'hA8000007));
      send_rand(11'h080);
      try_reject();
      pulse_finish();
      wait_done();

      // invalid classes, then bex
      pulse_start();
      send(11'h000, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
      send(11'h600, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
      chk("err_set", 64'(err), 64'(1));
      send(11'h002, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd3);
      repeat (3) @(posedge clock);
      #1;
      chk("bex_word", 64'(last_data), 64'(32'hB0000003));
      pulse_finish();
      wait_done();
      pulse_start();
      chk("err_cleared", 64'(err), 64'(0));

      // finish in the same cycle as the last transfer
      send_rand(11'h100);
      send_rand(11'h004);
      finish = 1'b1;
      send_rand(11'h020);
      finish = 1'b0;
      wait_done();

      // reset in the middle of a load
      pulse_start();
      send_rand(11'h010);
      send_rand(11'h200);
      reset_n = 1'b0;
      exp_q.delete();
      open = 0;
      #1;
      chk("async_rst_wren", 64'(imem_wren), 64'(0));
      chk("async_rst_addr_data", 64'({imem_addr, imem_data}), 64'(0));
      chk("async_rst_flags", 64'({in_ready, busy, done, err}), 64'(0));
      chk("async_rst_count", 64'(count), 64'(0));
      saved = nwrites;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      chk("no_write_after_reset", 64'(nwrites), 64'(saved));

      // randomized sessions
      for (int s = 0; s < 25; s++) begin
         int n = $urandom_range(1, MAXW);
         pulse_start();
         while (sess_n < n) begin
            send_rand(rand_sel());
            if ($urandom_range(0, 9) == 0) pulse_start();
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
         end
         if (sess_n == MAXW) try_reject();
         pulse_finish();
         wait_done();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
